imm_enc: RTL and testbench
==========================

Name: imm_enc

Overview:
- Inverse of the immediate decoder: merges a signed 32-bit immediate into a base RV32I instruction word at the bit positions defined by the instruction type.
- Used by the instruction-memory loader and self-test sequencer to build instructions.
- Range-checks the immediate and flags unencodable values.
- Results are buffered in a small output FIFO with valid/ready handshakes on both sides.

Parameters:
- FIFO_DEPTH, 2, output buffer entries; power of two, >= 2.
- CNT_W, 8, width of the saturating error counter.

Ports:
- imm_enc_clk  input  1  clock; all state updates on the rising edge.
- imm_enc_rst_n  input  1  asynchronous, active-low reset.
- imm_enc_in_valid  input  1  request valid.
- imm_enc_in_ready  output  1  request accepted when valid && ready.
- imm_enc_base_in  input  32  base instruction; opcode, rd, rs1, rs2, funct3 and funct7 taken from here.
- imm_enc_imm_in  input  32  signed immediate, two's complement.
- imm_enc_instr_type  input  4  instruction type code, same coding as the immediate decoder.
- imm_enc_out_valid  output  1  head FIFO entry valid.
- imm_enc_out_ready  input  1  consumer accepts the head entry.
- imm_enc_instr_out  output  32  encoded instruction, head entry.
- imm_enc_err_out  output  1  head entry was unencodable.
- imm_enc_err_cnt  output  CNT_W  saturating count of errored requests accepted.

Behaviour:
- Reset (async assert, sync-style deassert on next edge):
  - FIFO empty; out_valid=0, instr_out=0, err_out=0, err_cnt=0.
  - in_ready=1 once rst_n is high.
- Type coding and merge. Immediate bit positions in the base word are overwritten; all other bits pass unchanged.
  - 4'b0001 R: base passed through; imm ignored; never errors.
  - 4'b0010..4'b0101 I: [31:20]=imm[11:0]. Legal range -2048..2047.
  - 4'b0110 S: [31:25]=imm[11:5], [11:7]=imm[4:0]. Legal range -2048..2047.
  - 4'b0111 B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]. Legal range -4096..4094; imm[0] must be 0.
  - Any other code: error.
- Error handling:
  - Entry stored with instr=32'h0000_0000 and err=1.
  - err_cnt increments on acceptance and saturates at all-ones.
- Range check is a full 32-bit signed comparison: imm[31:11] must all equal imm[11] (I/S), or imm[31:12] must all equal imm[12] (B).
- Handshake and latency:
  - Request accepted on an edge where in_valid && in_ready. Encoding is combinational at write time.
  - An accepted entry is visible on instr_out/out_valid in the following cycle: 1-cycle latency into an empty FIFO.
  - in_ready = !full, registered-equivalent. No combinational path from out_ready to in_ready.
  - Head pops on an edge where out_valid && out_ready.
  - Outputs stay stable while out_valid && !out_ready.
- FIFO:
  - Circular buffer; read/write pointers wrap modulo FIFO_DEPTH; occupancy counter 0..FIFO_DEPTH.
  - Push and pop in the same edge while not empty and not full: occupancy unchanged, both pointers advance.
  - Full: in_ready=0; requests held upstream, none dropped. A pop while full frees a slot; in_ready rises the next cycle.
  - Empty: out_valid=0; instr_out/err_out hold their last value (don't-care).
- Reset mid-operation: FIFO flushed immediately, entries lost, err_cnt cleared.
- Input values are don't-care while in_valid=0.

Test Plan:
- I-type: base 32'h00000093, imm=5 -> 32'h00500093, err=0. Same base, imm=32'hFFFFFFFF -> 32'hFFF00093.
- S-type: base 32'h0020A023, imm=8 -> 32'h0020A423. Same base, imm=-4 -> 32'hFE20AE23.
- B-type:
  - base 32'h00000063, imm=8 -> 32'h00000463.
  - imm=-4096 -> 32'h80000063.
  - imm=3 -> instr=0, err=1, err_cnt=1.
- Range/type errors:
  - I-type imm=2048 -> err=1.
  - I-type imm=-2049 -> err=1.
  - Type 4'b1111 -> err=1.
  - err_cnt after these three errors = 3.
  - With CNT_W=2 and 5 errors -> err_cnt=3 (saturated).
- Backpressure:
  - Hold out_ready=0 and push 3 requests -> in_ready drops after 2 pushes; third request waits.
  - Raise out_ready -> outputs in order, 1 per cycle; third accepted the cycle after the first pop.
- Reset with 2 entries queued: pull rst_n low asynchronously mid-cycle -> out_valid=0 immediately, err_cnt=0; next push after release appears with 1-cycle latency.

Source files
------------

// File: rtl/imm_enc.sv
// imm_enc: merges a signed immediate into a base RV32I instruction word
// at the bit positions of the selected instruction type, range-checks the
// immediate, and queues {instr, err} results in a small output FIFO.
module imm_enc #(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 8
) (
    input  logic             imm_enc_clk,
    input  logic             imm_enc_rst_n,
    input  logic             imm_enc_in_valid,
    output logic             imm_enc_in_ready,
    input  logic [31:0]      imm_enc_base_in,
    input  logic [31:0]      imm_enc_imm_in,
    input  logic [3:0]       imm_enc_instr_type,
    output logic             imm_enc_out_valid,
    input  logic             imm_enc_out_ready,
    output logic [31:0]      imm_enc_instr_out,
    output logic             imm_enc_err_out,
    output logic [CNT_W-1:0] imm_enc_err_cnt
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic        err;
        logic [31:0] instr;
    } entry_t;

    entry_t               mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [OCC_W-1:0]     occ_q, occ_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    entry_t               enc;
    logic                 ok_is, ok_b;
    logic                 push, pop;

    // Sign-extension check: the immediate fits iff all bits above the top
    // encodable bit equal that bit. B-type also needs an even offset.
    assign ok_is = (&imm_enc_imm_in[31:11]) | ~(|imm_enc_imm_in[31:11]);
    assign ok_b  = ((&imm_enc_imm_in[31:12]) | ~(|imm_enc_imm_in[31:12])) & ~imm_enc_imm_in[0];

    // Merge the immediate into the base word; unencodable requests become {0, err}.
    always_comb begin
        enc.err   = 1'b0;
        enc.instr = imm_enc_base_in;
        case (imm_enc_instr_type)
            4'b0001: ;
            4'b0010, 4'b0011, 4'b0100, 4'b0101: begin
                enc.err            = ~ok_is;
                enc.instr[31:20]   = imm_enc_imm_in[11:0];
            end
            4'b0110: begin
                enc.err            = ~ok_is;
                enc.instr[31:25]   = imm_enc_imm_in[11:5];
                enc.instr[11:7]    = imm_enc_imm_in[4:0];
            end
            4'b0111: begin
                enc.err            = ~ok_b;
                enc.instr[31]      = imm_enc_imm_in[12];
                enc.instr[30:25]   = imm_enc_imm_in[10:5];
                enc.instr[11:8]    = imm_enc_imm_in[4:1];
                enc.instr[7]       = imm_enc_imm_in[11];
            end
            default: enc.err = 1'b1;
        endcase
        if (enc.err) enc.instr = '0;
    end

    // in_ready/out_valid come straight from the occupancy register, so there
    // is no combinational path from out_ready to in_ready.
    assign imm_enc_in_ready  = (occ_q != OCC_W'(FIFO_DEPTH));
    assign imm_enc_out_valid = (occ_q != '0);
    assign imm_enc_instr_out = mem_q[rd_q].instr;
    assign imm_enc_err_out   = mem_q[rd_q].err;
    assign imm_enc_err_cnt   = cnt_q;

    assign push = imm_enc_in_valid & imm_enc_in_ready;
    assign pop  = imm_enc_out_valid & imm_enc_out_ready;

    // Next-state for pointers, occupancy and the saturating error counter.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        occ_d = occ_q;
        cnt_d = cnt_q;
        if (push) wr_d = wr_q + PTR_W'(1);
        if (pop)  rd_d = rd_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
        if (push && enc.err && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    end

    // State registers; storage is cleared so outputs read zero after reset.
    always_ff @(posedge imm_enc_clk or negedge imm_enc_rst_n) begin
        if (!imm_enc_rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            occ_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            occ_q <= occ_d;
            cnt_q <= cnt_d;
            if (push) mem_q[wr_q] <= enc;
        end
    end

endmodule

// File: tb/tb_imm_enc.sv
// Bench for imm_enc: directed vector table, backpressure and reset
// sequences, a saturation check on a narrow-counter instance, and a
// randomized run against a reference model plus expected-output queue.
module tb_imm_enc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid, err_out;
    logic [31:0] base = '0, imm = '0, instr_out;
    logic [3:0]  typ = '0;
    logic [7:0]  err_cnt;

    logic        in_valid2 = 1'b0;
    logic        in_ready2, out_valid2, err_out2;
    logic [31:0] instr_out2;
    logic [1:0]  err_cnt2;

    int n_total = 0, n_pass = 0;

    always #5 clk = ~clk;

    imm_enc #(.FIFO_DEPTH(2), .CNT_W(8)) dut (
        .imm_enc_clk(clk), .imm_enc_rst_n(rst_n),
        .imm_enc_in_valid(in_valid), .imm_enc_in_ready(in_ready),
        .imm_enc_base_in(base), .imm_enc_imm_in(imm), .imm_enc_instr_type(typ),
        .imm_enc_out_valid(out_valid), .imm_enc_out_ready(out_ready),
        .imm_enc_instr_out(instr_out), .imm_enc_err_out(err_out),
        .imm_enc_err_cnt(err_cnt)
    );

    imm_enc #(.FIFO_DEPTH(2), .CNT_W(2)) dut2 (
        .imm_enc_clk(clk), .imm_enc_rst_n(rst_n),
        .imm_enc_in_valid(in_valid2), .imm_enc_in_ready(in_ready2),
        .imm_enc_base_in(32'h0000_0093), .imm_enc_imm_in(32'h0), .imm_enc_instr_type(4'hF),
        .imm_enc_out_valid(out_valid2), .imm_enc_out_ready(1'b1),
        .imm_enc_instr_out(instr_out2), .imm_enc_err_out(err_out2),
        .imm_enc_err_cnt(err_cnt2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: arithmetic range checks and shift/mask placement of fields.
    function automatic logic [32:0] ref_enc(input logic [31:0] b, input logic [31:0] im,
                                            input logic [3:0] t);
        int v;
        logic [31:0] u;
        v = signed'(im);
        u = im;
        if (t == 4'd1) return {1'b0, b};
        if (t >= 4'd2 && t <= 4'd5) begin
            if (v < -2048 || v > 2047) return {1'b1, 32'h0};
            return {1'b0, (b & 32'h000F_FFFF) | ((u & 32'hFFF) << 20)};
        end
        if (t == 4'd6) begin
            if (v < -2048 || v > 2047) return {1'b1, 32'h0};
            return {1'b0, (b & 32'h01FF_F07F) | (((u >> 5) & 32'h7F) << 25) | ((u & 32'h1F) << 7)};
        end
        if (t == 4'd7) begin
            if (v < -4096 || v > 4094 || (v % 2) != 0) return {1'b1, 32'h0};
            return {1'b0, (b & 32'h01FF_F07F) | (((u >> 12) & 32'h1) << 31)
                    | (((u >> 5) & 32'h3F) << 25) | (((u >> 1) & 32'hF) << 8)
                    | (((u >> 11) & 32'h1) << 7)};
        end
        return {1'b1, 32'h0};
    endfunction

    typedef struct {
        logic [31:0] base;
        logic [31:0] imm;
        logic [3:0]  typ;
        logic [31:0] exp_instr;
        logic        exp_err;
        logic [7:0]  exp_cnt;
    } vec_t;

    vec_t vecs[12];
    logic [32:0] q[$];
    logic [7:0]  mcnt;

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_valid2 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{32'h0000_0093, 32'd5,          4'd2, 32'h0050_0093, 1'b0, 8'd0};
        vecs[1]  = '{32'h0000_0093, 32'hFFFF_FFFF,  4'd3, 32'hFFF0_0093, 1'b0, 8'd0};
        vecs[2]  = '{32'h0020_A023, 32'd8,          4'd6, 32'h0020_A423, 1'b0, 8'd0};
        vecs[3]  = '{32'h0020_A023, -32'sd4,        4'd6, 32'hFE20_AE23, 1'b0, 8'd0};
        vecs[4]  = '{32'h0000_0063, 32'd8,          4'd7, 32'h0000_0463, 1'b0, 8'd0};
        vecs[5]  = '{32'h0000_0063, -32'sd4096,     4'd7, 32'h8000_0063, 1'b0, 8'd0};
        vecs[6]  = '{32'h0000_0063, 32'd3,          4'd7, 32'h0000_0000, 1'b1, 8'd1};
        vecs[7]  = '{32'h0000_0093, 32'd2048,       4'd4, 32'h0000_0000, 1'b1, 8'd2};
        vecs[8]  = '{32'h0000_0093, -32'sd2049,     4'd5, 32'h0000_0000, 1'b1, 8'd3};
        vecs[9]  = '{32'h0000_0093, 32'd0,          4'hF, 32'h0000_0000, 1'b1, 8'd4};
        vecs[10] = '{32'h1234_5678, 32'hDEAD_BEEF,  4'd1, 32'h1234_5678, 1'b0, 8'd4};
        vecs[11] = '{32'h0000_0063, 32'd4094,       4'd7, 32'h7E00_0FE3, 1'b0, 8'd4};

        // Reset state
        #12;
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_instr", instr_out, 32'h0);
        chk("rst_err", {31'h0, err_out}, 32'h0);
        chk("rst_err_cnt", {24'h0, err_cnt}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);

        // Directed vectors, one at a time into an empty FIFO
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            base = vecs[i].base; imm = vecs[i].imm; typ = vecs[i].typ;
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            chk($sformatf("vec%0d_valid", i), {31'h0, out_valid}, 32'h1);
            chk($sformatf("vec%0d_instr", i), instr_out, vecs[i].exp_instr);
            chk($sformatf("vec%0d_err", i), {31'h0, err_out}, {31'h0, vecs[i].exp_err});
            chk($sformatf("vec%0d_cnt", i), {24'h0, err_cnt}, {24'h0, vecs[i].exp_cnt});
            @(negedge clk);
            chk($sformatf("vec%0d_drained", i), {31'h0, out_valid}, 32'h0);
        end

        // Saturation on a 2-bit counter
        in_valid2 = 1'b1;
        repeat (2) @(negedge clk);
        chk("sat_cnt_2", {30'h0, err_cnt2}, 32'd2);
        repeat (3) @(negedge clk);
        in_valid2 = 1'b0;
        chk("sat_cnt_5", {30'h0, err_cnt2}, 32'd3);

        // Backpressure: three requests with consumer stalled
        out_ready = 1'b0;
        base = 32'h0000_0093; typ = 4'd2;
        imm = 32'd1; in_valid = 1'b1;
        @(negedge clk);
        chk("bp_ready_after1", {31'h0, in_ready}, 32'h1);
        imm = 32'd2;
        @(negedge clk);
        chk("bp_ready_after2", {31'h0, in_ready}, 32'h0);
        imm = 32'd3;
        @(negedge clk);
        chk("bp_still_full", {31'h0, in_ready}, 32'h0);
        chk("bp_head_stable", instr_out, 32'h0010_0093);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_second", instr_out, 32'h0020_0093);
        chk("bp_ready_after_pop", {31'h0, in_ready}, 32'h1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_third", instr_out, 32'h0030_0093);
        chk("bp_third_valid", {31'h0, out_valid}, 32'h1);
        @(negedge clk);
        chk("bp_empty", {31'h0, out_valid}, 32'h0);

        // Asynchronous reset with two entries queued
        out_ready = 1'b0;
        typ = 4'hF; in_valid = 1'b1;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        chk("ar_pre_valid", {31'h0, out_valid}, 32'h1);
        chk("ar_pre_cnt", {24'h0, err_cnt}, 32'd6);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_out_valid", {31'h0, out_valid}, 32'h0);
        chk("ar_err_cnt", {24'h0, err_cnt}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        typ = 4'd2; imm = 32'd7; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("ar_post_valid", {31'h0, out_valid}, 32'h1);
        chk("ar_post_instr", instr_out, 32'h0070_0093);

        // Randomized run against the reference model
        do_reset();
        q.delete();
        mcnt = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            chk("rnd_in_ready", {31'h0, in_ready}, {31'h0, (q.size() < 2)});
            chk("rnd_out_valid", {31'h0, out_valid}, {31'h0, (q.size() != 0)});
            chk("rnd_err_cnt", {24'h0, err_cnt}, {24'h0, mcnt});
            if (q.size() != 0) chk("rnd_head", {instr_out[31:1], instr_out[0] ^ err_out},
                                   {q[0][31:1], q[0][0] ^ q[0][32]});
            if (q.size() != 0) chk("rnd_head_err", {31'h0, err_out}, {31'h0, q[0][32]});
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            base = $urandom();
            typ  = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0: imm = $urandom();
                1: imm = 32'(int'($urandom_range(0, 10000)) - 5000);
                2: imm = 32'(int'($urandom_range(0, 8)) - 4);
                default: begin
                    case ($urandom_range(0, 5))
                        0: imm = 32'd2047;   1: imm = -32'sd2048;
                        2: imm = 32'd4094;   3: imm = -32'sd4096;
                        4: imm = 32'd4095;   default: imm = -32'sd4097;
                    endcase
                end
            endcase
            if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
            if (in_valid && in_ready) begin
                logic [32:0] e;
                e = ref_enc(base, imm, typ);
                q.push_back(e);
                if (e[32] && mcnt != 8'hFF) mcnt++;
            end
        end
        in_valid = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
